grn_step_ctrl: RTL and testbench

//  Sequencer for a bank of N_NODES two-phase GRN nodes. One node has state regs s0/s1,

---
 rtl/grn_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_grn_step_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/grn_step_ctrl.sv
// Sequencer for a bank of two-phase GRN nodes: load, step (s0 then s1), detect
// fixed point or budget end, return result on a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cfg_valid/ready     run request handshake (ready only in IDLE)
//   cfg_init_state      initial node vector, latched on accept
//   cfg_max_steps       step budget (0 behaves as 1)
//   abort               abandon current run (ignored in IDLE)
//   reset_nos           node bank load strobe
//   init_state          latched initial vector to the nodes
//   start_s0/start_s1   phase update strobes
//   net_state           s0 outputs of all nodes
//   busy                high outside IDLE
//   res_valid/ready     result handshake
//   res_fixed           1 = fixed point, 0 = budget exhausted
//   res_steps           completed steps
//   res_state           net_state sampled at the final check
module grn_step_ctrl #(
  parameter int N_NODES      = 4,
  parameter int CNT_W        = 16,
  parameter int STABLE_STEPS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [N_NODES-1:0] cfg_init_state,
  input  logic [CNT_W-1:0]   cfg_max_steps,
  input  logic               abort,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] net_state,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_fixed,
  output logic [CNT_W-1:0]   res_steps,
  output logic [N_NODES-1:0] res_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PH0   = 3'd2;
  localparam logic [2:0] S_PH1   = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_STEPS);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [2:0]         state_q, state_d;
  logic [N_NODES-1:0] init_q, init_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   stable_q, stable_d;
  logic [N_NODES-1:0] snap_q, snap_d;
  logic               fixed_q, fixed_d;

  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    budget_d = budget_q;
    step_d   = step_q;
    stable_d = stable_q;
    snap_d   = snap_q;
    fixed_d  = fixed_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          init_d   = cfg_init_state;
          // a zero budget still runs one step
          budget_d = (cfg_max_steps == '0) ? ONE_C
                                           : cfg_max_steps;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        step_d   = '0;
        stable_d = '0;
        snap_d   = init_q;
        fixed_d  = 1'b0;
        state_d  = S_PH0;
      end
      S_PH0: state_d = S_PH1;
      S_PH1: state_d = S_CHECK;
      S_CHECK: begin
        step_d   = step_q + ONE_C;
        stable_d = (net_state == snap_q)
                 ? stable_q + ONE_C : '0;
        snap_d   = net_state;
        // fixed point takes precedence over budget end
        if (stable_d == STABLE_C) begin
          fixed_d = 1'b1;
          state_d = S_DONE;
        end else if (step_d == budget_q) begin
          fixed_d = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_PH0;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      init_q   <= '0;
      budget_q <= '0;
      step_q   <= '0;
      stable_q <= '0;
      snap_q   <= '0;
      fixed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      budget_q <= budget_d;
      step_q   <= step_d;
      stable_q <= stable_d;
      snap_q   <= snap_d;
      fixed_q  <= fixed_d;
    end
  end

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign reset_nos  = (state_q == S_LOAD);
  assign start_s0   = (state_q == S_PH0);
  assign start_s1   = (state_q == S_PH1);
  assign res_valid  = (state_q == S_DONE);
  assign init_state = init_q;
  assign res_fixed  = fixed_q;
  assign res_steps  = step_q;
  assign res_state  = snap_q;

endmodule

// File: tb/tb_grn_step_ctrl.sv
// Scoreboard bench for grn_step_ctrl with a behavioural node bank
// that either holds or inverts its state on every start_s0.
module tb_grn_step_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct {
    logic         fixed;
    logic [W-1:0] steps;
    logic [N-1:0] st;
  } exp_t;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         cfg_valid = 0;
  logic         cfg_ready;
  logic [N-1:0] cfg_init_state = '0;
  logic [W-1:0] cfg_max_steps = '0;
  logic         abort = 0;
  logic         reset_nos;
  logic [N-1:0] init_state;
  logic         start_s0, start_s1;
  logic [N-1:0] net_state;
  logic         busy, res_valid;
  logic         res_ready = 0;
  logic         res_fixed;
  logic [W-1:0] res_steps;
  logic [N-1:0] res_state;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic toggle = 0;
  logic [N-1:0] node_q;

  grn_step_ctrl #(
    .N_NODES(N), .CNT_W(W), .STABLE_STEPS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_init_state(cfg_init_state),
    .cfg_max_steps(cfg_max_steps),
    .abort(abort), .reset_nos(reset_nos),
    .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .net_state(net_state), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_fixed(res_fixed), .res_steps(res_steps),
    .res_state(res_state)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset_nos) node_q <= init_state;
    else if (start_s0 && toggle) node_q <= ~node_q;
  end
  assign net_state = node_q;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One run: push expectation, issue cfg, watch strobes, take result.
  task automatic run(input logic [N-1:0] init,
                     input logic [W-1:0] bud,
                     input logic tog,
                     input logic e_fix,
                     input int e_steps,
                     input int hold);
    exp_t e, g;
    int cyc, n0, n1;
    logic f0;
    logic [W-1:0] s0;
    logic [N-1:0] st0;
    e.fixed = e_fix;
    e.steps = W'(e_steps);
    e.st = (tog && e_steps[0]) ? ~init : init;
    sb_q.push_back(e);
    toggle = tog;
    @(negedge clk);
    cfg_valid = 1;
    cfg_init_state = init;
    cfg_max_steps = bud;
    @(negedge clk);
    cfg_valid = 0;
    chk("load_strobe", 32'(reset_nos), 1);
    cyc = 1; n0 = 0; n1 = 0;
    while (!res_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      n0 += int'(start_s0);
      n1 += int'(start_s1);
    end
    chk("res_valid_seen", 32'(res_valid), 1);
    chk("latency", 32'(cyc), 32'(3 * e_steps + 2));
    chk("s0_pulses", 32'(n0), 32'(e_steps));
    chk("s1_pulses", 32'(n1), 32'(e_steps));
    f0 = res_fixed; s0 = res_steps; st0 = res_state;
    if (hold > 0) begin
      cfg_valid = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(res_valid), 1);
        chk("hold_cfg_rdy", 32'(cfg_ready), 0);
        chk("hold_fixed", 32'(res_fixed), 32'(f0));
        chk("hold_steps", 32'(res_steps), 32'(s0));
        chk("hold_state", 32'(res_state), 32'(st0));
      end
      cfg_valid = 0;
    end
    chk("sb_depth", 32'(sb_q.size()), 1);
    if (sb_q.size() > 0) begin
      g = sb_q.pop_front();
      chk("res_fixed", 32'(res_fixed), 32'(g.fixed));
      chk("res_steps", 32'(res_steps), 32'(g.steps));
      chk("res_state", 32'(res_state), 32'(g.st));
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("back_idle", 32'(cfg_ready), 1);
    chk("valid_drop", 32'(res_valid), 0);
  endtask

  initial begin
    int k, n1;
    #12;
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({reset_nos, start_s0,
                            start_s1, res_valid}), 0);
    chk("rst_res", 32'({res_fixed, res_steps,
                        res_state, init_state}), 0);
    @(negedge clk);
    rst_n = 1;
    // fixed point on a constant vector
    run(4'hA, 16'd100, 0, 1, 2, 0);
    // toggling vector hits the budget
    run(4'h5, 16'd5, 1, 0, 5, 0);
    // zero budget behaves as one step
    run(4'h3, 16'd0, 1, 0, 1, 0);
    // fixed point and budget on the same check
    run(4'h6, 16'd2, 0, 1, 2, 0);
    // abort in PH1 of step 3
    toggle = 1;
    @(negedge clk);
    cfg_valid = 1;
    cfg_init_state = 4'h9;
    cfg_max_steps = 16'd100;
    @(negedge clk);
    cfg_valid = 0;
    n1 = 0; k = 0;
    while (n1 < 3 && k < 100) begin
      @(negedge clk);
      k++;
      n1 += int'(start_s1);
    end
    chk("ph1_step3", 32'(n1), 3);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_idle", 32'(cfg_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_novalid", 32'(res_valid), 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", 32'(res_valid), 0);
    end
    // reload after abort, and a long hold in DONE
    run(4'hC, 16'd3, 1, 0, 3, 10);
    // async reset mid-run
    @(negedge clk);
    cfg_valid = 1;
    cfg_init_state = 4'h1;
    cfg_max_steps = 16'd50;
    @(negedge clk);
    cfg_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_strobes", 32'({reset_nos, start_s0,
                             start_s1, res_valid}), 0);
    chk("arst_cfg_ready", 32'(cfg_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    run(4'hF, 16'd7, 0, 1, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
